// File: rtl/pi_pdc_scan_pkg.sv
// Shared types for the pad scan-chain sequencer: command opcodes, FSM states and
// scan-clock phase numbering.
package pi_pdc_scan_pkg;

  typedef enum logic [1:0] {
    SCAN_OP_SHIFT       = 2'b00,
    SCAN_OP_CAPTURE     = 2'b01,
    SCAN_OP_CHAIN_RESET = 2'b10,
    SCAN_OP_RSVD        = 2'b11
  } scan_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SRST    = 3'd3,
    ST_RESP    = 3'd4
  } scan_state_e;

  localparam logic [1:0] PH_SC0  = 2'd0;
  localparam logic [1:0] PH_GAP0 = 2'd1;
  localparam logic [1:0] PH_SC1  = 2'd2;
  localparam logic [1:0] PH_GAP1 = 2'd3;

endpackage

// File: rtl/pi_pdc_scan_clkgen.sv
// Four-phase scan clock generator: SC0 in phase 0, SC1 in phase 2, idle gaps
// between them so the two phases can never overlap.
module pi_pdc_scan_clkgen
  import pi_pdc_scan_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  output logic [1:0] ph,
  output logic       run,
  output logic       sc0,
  output logic       sc1,
  output logic       bit_done
);

  logic [1:0] ph_next;
  logic       sc0_next;
  logic       sc1_next;

  assign ph_next  = start ? PH_SC0 : ph + 2'd1;
  assign bit_done = run && (ph == PH_GAP1);

  always_comb begin
    sc0_next = 1'b0;
    sc1_next = 1'b0;
    case (ph_next)
      PH_SC0:  sc0_next = 1'b1;
      PH_SC1:  sc1_next = 1'b1;
      PH_GAP0: ;
      PH_GAP1: ;
      default: ;
    endcase
  end

  // Phase outputs are registered from the next phase so they align with ph.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      ph  <= PH_SC0;
      run <= 1'b0;
      sc0 <= 1'b0;
      sc1 <= 1'b0;
    end else begin
      ph  <= ph_next;
      run <= 1'b1;
      sc0 <= sc0_next;
      sc1 <= sc1_next;
    end
  end

endmodule

// File: rtl/pi_pdc_scan_chain_ctrl.sv
// Pad scan-chain sequencer: SHIFT / CAPTURE / CHAIN_RESET over valid/ready.
// Define PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN to add expected-data compare on SHIFT.
module pi_pdc_scan_chain_ctrl
  import pi_pdc_scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = 16,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                 pi_pdc_scan_chain_ctrl_clk,
  input  logic                 pi_pdc_scan_chain_ctrl_reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_wdata,
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
  input  logic [CHAIN_LEN-1:0] cmd_expect,
  output logic [CHAIN_LEN-1:0] rsp_mismatch,
`endif
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 SE0,
  output logic                 SE1,
  output logic                 SC0,
  output logic                 SC1,
  output logic                 SR,
  output logic                 scan_head_out,
  input  logic                 scan_tail_in,
  output logic                 busy
);

  localparam int unsigned BW  = $clog2(CHAIN_LEN);
  localparam int unsigned RCW = 4;

  scan_state_e          state;
  scan_op_e             op;
  logic [BW-1:0]        bitc;
  logic [RCW-1:0]       rcnt;
  logic [CHAIN_LEN-1:0] sreg;
  logic [CHAIN_LEN-1:0] rbuf;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
  logic [CHAIN_LEN-1:0] exp_q;
`endif
  logic                 accept;
  logic                 last_bit;
  logic                 cg_enable;
  logic                 cg_start;
  logic                 bit_done;
  logic                 run;
  logic [1:0]           ph;

  assign op       = scan_op_e'(cmd_op);
  assign accept   = cmd_valid && cmd_ready;
  assign last_bit = (bitc == BW'(CHAIN_LEN - 1));

  // Keep the phase generator running until the last bit's final phase.
  always_comb begin
    cg_start  = 1'b0;
    cg_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && ((op == SCAN_OP_SHIFT) || (op == SCAN_OP_CAPTURE))) begin
          cg_start  = 1'b1;
          cg_enable = 1'b1;
        end
      end
      ST_SHIFT:   cg_enable = !(bit_done && last_bit);
      ST_CAPTURE: cg_enable = !bit_done;
      default:    ;
    endcase
  end

  pi_pdc_scan_clkgen u_clkgen (
    .clk      (pi_pdc_scan_chain_ctrl_clk),
    .reset    (pi_pdc_scan_chain_ctrl_reset),
    .enable   (cg_enable),
    .start    (cg_start),
    .ph       (ph),
    .run      (run),
    .sc0      (SC0),
    .sc1      (SC1),
    .bit_done (bit_done)
  );

  always_ff @(posedge pi_pdc_scan_chain_ctrl_clk) begin
    if (pi_pdc_scan_chain_ctrl_reset) begin
      state         <= ST_IDLE;
      bitc          <= '0;
      rcnt          <= '0;
      sreg          <= '0;
      rbuf          <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      SE0           <= 1'b0;
      SE1           <= 1'b0;
      SR            <= 1'b0;
      scan_head_out <= 1'b0;
      busy          <= 1'b0;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
      exp_q         <= '0;
      rsp_mismatch  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            bitc      <= '0;
            rbuf      <= '0;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
            exp_q     <= cmd_expect;
`endif
            case (op)
              SCAN_OP_SHIFT: begin
                state         <= ST_SHIFT;
                SE0           <= 1'b1;
                SE1           <= 1'b1;
                scan_head_out <= cmd_wdata[0];
                sreg          <= cmd_wdata >> 1;
              end
              SCAN_OP_CAPTURE: state <= ST_CAPTURE;
              SCAN_OP_CHAIN_RESET: begin
                state <= ST_SRST;
                SR    <= 1'b1;
                rcnt  <= RCW'(RST_CYCLES - 1);
              end
              default: begin
                // Reserved opcode: no scan activity, flagged error response.
                state     <= ST_RESP;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
                rsp_mismatch <= '0;
`endif
              end
            endcase
          end
        end
        ST_SHIFT: begin
          if (run && (ph == PH_SC0)) rbuf[bitc] <= scan_tail_in;
          if (bit_done) begin
            if (last_bit) begin
              state         <= ST_RESP;
              SE0           <= 1'b0;
              SE1           <= 1'b0;
              scan_head_out <= 1'b0;
              rsp_valid     <= 1'b1;
              rsp_rdata     <= rbuf;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
              rsp_mismatch  <= rbuf ^ exp_q;
              rsp_err       <= |(rbuf ^ exp_q);
`else
              rsp_err       <= 1'b0;
`endif
            end else begin
              bitc          <= bitc + 1'b1;
              scan_head_out <= sreg[0];
              sreg          <= sreg >> 1;
            end
          end
        end
        ST_CAPTURE: begin
          if (bit_done) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
            rsp_mismatch <= '0;
`endif
          end
        end
        ST_SRST: begin
          if (rcnt == '0) begin
            SR        <= 1'b0;
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
            rsp_mismatch <= '0;
`endif
          end else begin
            rcnt <= rcnt - 1'b1;
          end
        end
        ST_RESP: begin
          // Response fields stay frozen until the consumer takes them.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_pdc_scan_chain_ctrl.sv
// Directed bench for pi_pdc_scan_chain_ctrl with a two-phase pad chain model and
// a response scoreboard; covers PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN when defined.
module tb_pi_pdc_scan_chain_ctrl;

  localparam int unsigned N = 16;
  localparam logic [1:0] OP_SHIFT = 2'b00;
  localparam logic [1:0] OP_CAP   = 2'b01;
  localparam logic [1:0] OP_SRST  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_wdata;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
  logic [N-1:0] cmd_expect, rsp_mismatch;
`endif
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [N-1:0] rsp_rdata;
  logic         SE0, SE1, SC0, SC1, SR, head, tail, busy;

  always #5 clk = ~clk;

  pi_pdc_scan_chain_ctrl #(.CHAIN_LEN(N), .RST_CYCLES(4)) dut (
    .pi_pdc_scan_chain_ctrl_clk   (clk),
    .pi_pdc_scan_chain_ctrl_reset (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_wdata     (cmd_wdata),
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
    .cmd_expect    (cmd_expect),
    .rsp_mismatch  (rsp_mismatch),
`endif
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .SE0           (SE0),
    .SE1           (SE1),
    .SC0           (SC0),
    .SC1           (SC1),
    .SR            (SR),
    .scan_head_out (head),
    .scan_tail_in  (tail),
    .busy          (busy)
  );

  // Pad chain: master latches on SC0 from the previous slave, slaves load on SC1.
  logic [N-1:0] mst, slv, pre_val;
  logic         pre_en;
  always @(posedge clk) begin
    if (pre_en) begin
      mst <= pre_val;
      slv <= pre_val;
    end else if (SR) begin
      mst <= '0;
      slv <= '0;
    end else begin
      if (SC0) mst <= {slv[N-2:0], head};
      if (SC1) slv <= mst;
    end
  end
  assign tail = slv[N-1];

  typedef struct {
    logic [N-1:0] rdata;
    logic         err;
    logic [N-1:0] mm;
    int           lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0, passes = 0, fails = 0;
  int k_lat, n_sc0, n_sc1, n_ovl, n_se, n_sr, n_sediff;
  logic [63:0] m_sc0, m_sc1, m_sr;

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < int'(N); i++) r[i] = v[N-1-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [N-1:0] v);
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk); #1;
    pre_en  = 1'b0;
  endtask

  task automatic push_exp(input logic [N-1:0] rd, input logic [N-1:0] ev,
                          input logic is_shift, input logic rsvd, input int lat);
    exp_t e;
    e.rdata = rd;
    e.mm    = is_shift ? (rd ^ ev) : '0;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
    e.err   = rsvd | (|e.mm);
`else
    e.err   = rsvd;
`endif
    e.lat   = lat;
    sb.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [N-1:0] wd, input logic [N-1:0] ev);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", 64'(n < 50), 64'(1));
    cmd_op    = op;
    cmd_wdata = wd;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
    cmd_expect = ev;
`else
    if (ev != ev) $display("unreachable");
`endif
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Sample every cycle after acceptance until rsp_valid (k_lat = T+k cycle index).
  task automatic collect();
    k_lat = 1; n_sc0 = 0; n_sc1 = 0; n_ovl = 0; n_se = 0; n_sr = 0; n_sediff = 0;
    m_sc0 = '0; m_sc1 = '0; m_sr = '0;
    while (!rsp_valid && k_lat < 200) begin
      n_sc0 += int'(SC0);
      n_sc1 += int'(SC1);
      n_ovl += int'(SC0 && SC1);
      n_se  += int'(SE0 && SE1);
      n_sediff += int'(SE0 != SE1);
      n_sr  += int'(SR);
      if (k_lat < 64) begin
        m_sc0[k_lat] = SC0;
        m_sc1[k_lat] = SC1;
        m_sr[k_lat]  = SR;
      end
      @(posedge clk); #1;
      k_lat++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 64'(rsp_valid), 64'(1));
      chk({tag, "_latency"}, 64'(k_lat), 64'(e.lat));
      chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
      chk({tag, "_err"}, 64'(rsp_err), 64'(e.err));
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
      chk({tag, "_mismatch"}, 64'(rsp_mismatch), 64'(e.mm));
`endif
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_after_hs"}, 64'({rsp_valid, busy, cmd_ready}), 64'(3'b001));
  endtask

  task automatic run_shift(input string tag, input logic [N-1:0] wd,
                           input logic [N-1:0] ev, input logic [N-1:0] rd);
    push_exp(rd, ev, 1'b1, 1'b0, 4 * N + 1);
    send(OP_SHIFT, wd, ev);
    collect();
    chk({tag, "_sc_pulses"}, 64'({n_sc0[15:0], n_sc1[15:0]}), 64'({16'(N), 16'(N)}));
    chk({tag, "_overlap"}, 64'(n_ovl), 64'(0));
    chk({tag, "_se_cycles"}, 64'({n_se[15:0], n_sediff[15:0]}), 64'({16'(4 * N), 16'd0}));
    chk({tag, "_idle_lines"}, 64'({SE0, SE1, SC0, SC1, SR, n_sr[7:0]}), 64'(0));
    finish_rsp(tag);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    pre_en = 1'b0; pre_val = '0;
`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
    cmd_expect = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({SE0, SE1, SC0, SC1, SR, head, busy, cmd_ready,
                              rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    preload(rev(16'h0000));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'({cmd_ready, busy}), 64'(2'b10));

    // Loopback: write A5C3 into an empty chain, then read it back.
    run_shift("shift1", 16'hA5C3, 16'h0000, 16'h0000);
    run_shift("shift2", 16'h0000, 16'hA5C3, 16'hA5C3);

    // Chain reset: SR exactly for cycles T+1..T+4.
    preload(rev(16'hFFFF));
    push_exp('0, '0, 1'b0, 1'b0, 5);
    send(OP_SRST, 16'hFFFF, '0);
    collect();
    chk("srst_sr_mask", m_sr, 64'h1E);
    chk("srst_quiet", 64'({n_sc0[7:0], n_sc1[7:0], n_se[7:0]}), 64'(0));
    finish_rsp("srst");
    chk("srst_chain_cleared", 64'(slv), 64'(0));

    // Capture: single SC0 at T+1 and SC1 at T+3, scan enables low.
    push_exp('0, '0, 1'b0, 1'b0, 5);
    send(OP_CAP, 16'h1234, '0);
    collect();
    chk("cap_sc0_mask", m_sc0, 64'h2);
    chk("cap_sc1_mask", m_sc1, 64'h8);
    chk("cap_quiet", 64'({n_se[7:0], n_sr[7:0], n_sediff[7:0]}), 64'(0));
    finish_rsp("cap");

    // Reserved opcode: error response held while rsp_ready is low.
    push_exp('0, '0, 1'b0, 1'b1, 2);
    send(OP_RSVD, 16'hBEEF, '0);
    collect();
    chk("rsvd_quiet", 64'({n_sc0[7:0], n_sc1[7:0], n_sr[7:0], n_se[7:0]}), 64'(0));
    begin
      int stable = 0;
      cmd_valid = 1'b1;
      cmd_op    = OP_SHIFT;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        stable += int'(rsp_valid && rsp_err && (rsp_rdata == '0) && !cmd_ready && busy);
      end
      cmd_valid = 1'b0;
      chk("rsvd_hold", 64'(stable), 64'(10));
    end
    finish_rsp("rsvd");

    // Synchronous reset at bit 7 of a SHIFT; the pending response is dropped.
    push_exp('0, '0, 1'b1, 1'b0, 4 * N + 1);
    send(OP_SHIFT, 16'h5A5A, '0);
    k_lat = 1;
    while (k_lat < 29) begin
      @(posedge clk); #1;
      k_lat++;
    end
    chk("pre_reset_bit7_p0", 64'({SE0, SC0, busy}), 64'(3'b111));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_outputs", 64'({SE0, SE1, SC0, SC1, SR, head, busy, cmd_ready,
                                  rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    sb.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_mid_reset", 64'({cmd_ready, busy}), 64'(2'b10));
    preload(rev(16'h3C5A));
    run_shift("shift_post_rst", 16'h1111, 16'h3C5A, 16'h3C5A);
    run_shift("shift_post_rst2", 16'h0000, 16'h1111, 16'h1111);

`ifdef PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN
    // Expected-data compare: chain returns 00FE against expect 00FF.
    preload(rev(16'h00FE));
    run_shift("shift_check", 16'h0000, 16'h00FF, 16'h00FE);
`endif

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pi_pdc_scan_chain_ctrl.md
Name: pi_pdc_scan_chain_ctrl

Overview:
Sequencer for the daisy-chained pad scan flops of the pi_pdc_ecb1 IO tiles, linked sc_in to sc_out.
- Accepts SHIFT, CAPTURE and CHAIN_RESET commands over a valid/ready interface.
- Generates the global SE0/SE1/SC0/SC1/SR signals, including a two-phase non-overlapping scan clock.
- Serialises write data into the chain head and collects read data from the chain tail.
- Sits at fabric top level, one instance per IO scan chain.

Parameters:
CHAIN_LEN, 16, number of scan flops in the chain (2..64)
RST_CYCLES, 4, SR pulse width in cycles for CHAIN_RESET (1..15)

Ports:
pi_pdc_scan_chain_ctrl_clk  in  1  clock
pi_pdc_scan_chain_ctrl_reset  in  1  reset, synchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_op  in  2  00 SHIFT, 01 CAPTURE, 10 CHAIN_RESET, 11 reserved
cmd_wdata  in  CHAIN_LEN  shift-in data, bit 0 sent first
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_rdata  out  CHAIN_LEN  shift-out data, first bit received lands at bit 0
rsp_err  out  1  error flag for the response
SE0, SE1  out  1  scan enables (duplicated for fanout)
SC0, SC1  out  1  scan clock phases
SR  out  1  chain reset
scan_head_out  out  1  drives first pad sc_in
scan_tail_in  in  1  from last pad sc_out
busy  out  1  FSM not in IDLE

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous, active-high.
  - All outputs are registered.
  - Reset values: every output 0; rsp_rdata 0; FSM in IDLE.
- Reset mid-operation: next edge forces IDLE, drops SE/SC/SR to 0, discards any pending response.
- Command acceptance:
  - cmd_ready = (state==IDLE) && !rsp_valid.
  - A command is accepted at an edge where cmd_valid && cmd_ready; call that edge T.
  - cmd_wdata is latched into the shift register at T.
- States: IDLE, SHIFT, CAPTURE, SRST, RESP.
- Bit phase counter ph (0..3) and bit counter (clog2(CHAIN_LEN) bits). Phases per bit:
  - P0: SC0=1.
  - P1: SC0=SC1=0.
  - P2: SC1=1.
  - P3: SC0=SC1=0.
  - SC0 and SC1 are never high in the same cycle.
- SHIFT:
  - Cycles T+1 .. T+4*CHAIN_LEN.
  - SE0=SE1=1 throughout.
  - scan_head_out holds bit k for all four phases of bit k.
  - scan_tail_in is sampled in P0 of bit k into rdata[k].
  - After bit CHAIN_LEN-1 P3: SE drops and the FSM enters RESP.
- CAPTURE:
  - One 4-phase sequence (T+1..T+4) with SE0=SE1=0; scan_head_out=0.
  - rsp_rdata=0.
- SRST (CHAIN_RESET):
  - SR=1 for RST_CYCLES cycles starting T+1; SE/SC stay 0.
  - rsp_rdata=0.
- Reserved op 11: no scan activity; enter RESP at T+1 with rsp_err=1 and rsp_rdata=0.
- RESP:
  - rsp_valid=1 in the cycle after the last active cycle (SHIFT: T+4*CHAIN_LEN+1).
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - The FSM returns to IDLE on the handshake edge.
  - cmd_ready rises the cycle after the handshake; no back-to-back acceptance in the handshake cycle.
- cmd_valid outside IDLE is ignored.

Optional Feature:
- Macro: PI_PDC_SCAN_CHAIN_CTRL_CHECK_EN.
- When defined:
  - Adds input cmd_expect [CHAIN_LEN], latched at T.
  - Adds output rsp_mismatch [CHAIN_LEN] = rdata XOR expect, for SHIFT only; 0 otherwise.
  - rsp_err is also set for a SHIFT with any mismatch bit.
- When undefined: those ports are absent and rsp_err is set only for the reserved opcode.

Decomposition:
- Shared package pi_pdc_scan_pkg holds:
  - op enum (SCAN_OP_SHIFT/CAPTURE/CHAIN_RESET/RSVD);
  - state enum;
  - phase constants PH_SC0=0, PH_GAP0=1, PH_SC1=2, PH_GAP1=3.
- One natural sub-module: pi_pdc_scan_clkgen.
  - Contains the phase counter and the SC0/SC1 non-overlap generator.
  - Ports: enable, bit_done and phase outputs.

Test Plan:
- Loopback (scan_tail_in tied to a 16-deep behavioural chain model preloaded 0x0000); SHIFT wdata=0xA5C3 → SC0/SC1 each pulse 16 times, never overlapping; rsp_valid at T+65; rdata=0x0000. A second SHIFT wdata=0x0000 → rdata=0xA5C3.
- CHAIN_RESET with RST_CYCLES=4 → SR=1 exactly cycles T+1..T+4; SE, SC0 and SC1 all 0; rsp_rdata=0; rsp_err=0.
- CAPTURE → SE0=SE1=0, exactly one SC0 pulse at T+1 and one SC1 pulse at T+3; rsp_valid at T+5.
- Op=11 → no SC/SR activity; rsp_valid at T+2 with rsp_err=1. Hold rsp_ready=0 for 10 cycles → response stable, cmd_ready=0.
- Synchronous reset asserted at bit 7 of a SHIFT → next cycle all outputs 0, busy=0. A new SHIFT after reset completes normally.
- With CHECK_EN defined: SHIFT with expect=0x00FF while the chain returns 0x00FE → rsp_mismatch=0x0001, rsp_err=1.
